// File: rtl/systolic_scheduler_if.sv
// Control/status bundle between a systolic-array sequencer and its host.
interface systolic_scheduler_if #(
  parameter int unsigned ROWS = 4
);
  logic            en;
  logic            start;
  logic            reuse_weights;
  logic            invalidate;
  logic [ROWS-1:0] load_weight;
  logic [ROWS-1:0] enable_mult;
  logic            busy;
  logic            done;
  logic            weights_valid;

  modport master (
    output en, start, reuse_weights, invalidate,
    input  load_weight, enable_mult, busy, done, weights_valid
  );

  modport slave (
    input  en, start, reuse_weights, invalidate,
    output load_weight, enable_mult, busy, done, weights_valid
  );
endinterface

// File: rtl/systolic_scheduler.sv
// Sequences weight loading and the diagonal compute wavefront of a ROWS x COLS
// systolic array; all outputs are registered.
module systolic_scheduler #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned PE_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  systolic_scheduler_if.slave bus
);

  localparam int unsigned C  = (ROWS + COLS - 1) * PE_LATENCY;
  localparam int unsigned CW = $clog2(C + 1);
  localparam logic [ROWS-1:0] MSB_ONLY = ROWS'(1) << (ROWS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   step_q, step_d;
  logic [ROWS-1:0] lw_q, lw_d;
  logic [ROWS-1:0] em_q, em_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wv_q, wv_d;

  // Next-state and next-output logic; en=0 holds everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    lw_d    = lw_q;
    em_d    = em_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wv_d    = wv_q;
    if (bus.en) begin
      lw_d   = '0;
      em_d   = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            cnt_d  = '0;
            step_d = '0;
            busy_d = 1'b1;
            if (bus.reuse_weights && wv_q) begin
              state_d = ST_COMPUTE;
              em_d    = MSB_ONLY;
            end else begin
              state_d = ST_LOAD;
              lw_d    = ROWS'(1);
            end
          end
        end
        ST_LOAD: begin
          busy_d = 1'b1;
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d = ST_COMPUTE;
            cnt_d   = '0;
            step_d  = '0;
            em_d    = MSB_ONLY;
            wv_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            lw_d  = lw_q << 1;
          end
        end
        ST_COMPUTE: begin
          if (cnt_q == CW'(C - 1)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            step_d  = '0;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            // Wavefront advances one row every PE_LATENCY cycles.
            if (step_q == CW'(PE_LATENCY - 1)) begin
              step_d = '0;
              em_d   = (em_q >> 1) | MSB_ONLY;
            end else begin
              step_d = step_q + CW'(1);
              em_d   = em_q;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (bus.invalidate) wv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      lw_q    <= '0;
      em_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      lw_q    <= lw_d;
      em_q    <= em_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wv_q    <= wv_d;
    end
  end

  assign bus.load_weight   = lw_q;
  assign bus.enable_mult   = em_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.weights_valid = wv_q;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Drives two scheduler configurations with shared stimulus and compares them
// against an operation-level reference model.
module tb_systolic_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_scheduler_if #(.ROWS(2)) ifa ();
  systolic_scheduler_if #(.ROWS(4)) ifb ();

  systolic_scheduler #(.ROWS(2), .COLS(2), .PE_LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  systolic_scheduler #(.ROWS(4), .COLS(3), .PE_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct packed {
    logic [7:0] lw;
    logic [7:0] em;
    logic       busy;
    logic       done;
    logic       set_wv;
  } exp_t;

  exp_t mq0[$];
  exp_t mq1[$];
  exp_t cur [2];
  logic wv_m [2];
  logic m_en, m_start, m_reuse, m_inv;
  int   n_vec = 0;
  int   n_err = 0;
  int   da, db, cnt_a, cnt_b;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One enabled cycle consumes the next entry of the expected operation timeline.
  task automatic model_step(input int idx, input int rows, input int cols, input int pl);
    exp_t q[$];
    exp_t e;
    logic wv, ld;
    int   c, n;
    if (idx == 0) begin q = mq0; wv = wv_m[0]; end
    else          begin q = mq1; wv = wv_m[1]; end
    if (m_en) begin
      if (q.size() == 0 && m_start) begin
        ld = !(m_reuse && wv);
        c  = (rows + cols - 1) * pl;
        if (ld) begin
          for (int k = 0; k < rows; k++) begin
            e = '0; e.lw = 8'(1 << k); e.busy = 1'b1; q.push_back(e);
          end
        end
        for (int j = 0; j < c; j++) begin
          n = 1 + j / pl;
          if (n > rows) n = rows;
          e = '0;
          e.em     = 8'(((1 << n) - 1) << (rows - n));
          e.busy   = 1'b1;
          e.set_wv = ld && (j == 0);
          q.push_back(e);
        end
        e = '0; e.done = 1'b1; q.push_back(e);
        e = '0; q.push_back(e);
      end
      if (q.size() > 0) e = q.pop_front();
      else              e = '0;
      if (e.set_wv) wv = 1'b1;
      if (m_inv)    wv = 1'b0;
      cur[idx] = e;
    end
    if (idx == 0) begin mq0 = q; wv_m[0] = wv; end
    else          begin mq1 = q; wv_m[1] = wv; end
  endtask

  task automatic check_all();
    chk("a_load_weight",   8'(ifa.load_weight),   cur[0].lw);
    chk("a_enable_mult",   8'(ifa.enable_mult),   cur[0].em);
    chk("a_busy",          8'(ifa.busy),          8'(cur[0].busy));
    chk("a_done",          8'(ifa.done),          8'(cur[0].done));
    chk("a_weights_valid", 8'(ifa.weights_valid), 8'(wv_m[0]));
    chk("b_load_weight",   8'(ifb.load_weight),   cur[1].lw);
    chk("b_enable_mult",   8'(ifb.enable_mult),   cur[1].em);
    chk("b_busy",          8'(ifb.busy),          8'(cur[1].busy));
    chk("b_done",          8'(ifb.done),          8'(cur[1].done));
    chk("b_weights_valid", 8'(ifb.weights_valid), 8'(wv_m[1]));
  endtask

  task automatic cyc(input logic en, input logic st, input logic ru, input logic inv);
    ifa.en = en; ifa.start = st; ifa.reuse_weights = ru; ifa.invalidate = inv;
    ifb.en = en; ifb.start = st; ifb.reuse_weights = ru; ifb.invalidate = inv;
    m_en = en; m_start = st; m_reuse = ru; m_inv = inv;
    @(posedge clk);
    model_step(0, 2, 2, 4);
    model_step(1, 4, 3, 1);
    #1 check_all();
  endtask

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    cur[0] = '0; cur[1] = '0;
    wv_m[0] = 1'b0; wv_m[1] = 1'b0;
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked while still asserted.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  // Runs one operation from idle; reports the output cycle of each done pulse.
  task automatic run_op(input int len, input int stall_from, input int stall_to,
                        input logic ru, output int oa, output int ob);
    oa = 0; ob = 0;
    for (int m = 0; m < len; m++) begin
      cyc(!(m >= stall_from && m <= stall_to), m == 0, ru, 1'b0);
      if (ifa.done && oa == 0) oa = m + 1;
      if (ifb.done && ob == 0) ob = m + 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    ifa.en = 1'b0; ifa.start = 1'b0; ifa.reuse_weights = 1'b0; ifa.invalidate = 1'b0;
    ifb.en = 1'b0; ifb.start = 1'b0; ifb.reuse_weights = 1'b0; ifb.invalidate = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    #3 reset = 1'b0;

    run_op(20, -1, -1, 1'b0, da, db);
    chk("r031_done_cycle_a", 8'(da), 8'd15);
    chk("r036_done_cycle_b", 8'(db), 8'd11);

    run_op(16, -1, -1, 1'b1, da, db);
    chk("r032_done_cycle_a", 8'(da), 8'd13);
    chk("r032_done_cycle_b", 8'(db), 8'd7);

    run_op(22, 5, 7, 1'b0, da, db);
    chk("r033_done_cycle_a", 8'(da), 8'd18);
    chk("r033_done_cycle_b", 8'(db), 8'd14);

    for (int m = 0; m < 8; m++) cyc(1'b1, m == 0, 1'b0, 1'b0);
    pulse_reset();
    chk("r034_wv_a_after_reset", 8'(ifa.weights_valid), 8'h00);
    chk("r034_em_a_after_reset", 8'(ifa.enable_mult), 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("r034_reload_lw_a", 8'(ifa.load_weight), 8'h01);
    chk("r034_reload_lw_b", 8'(ifb.load_weight), 8'h01);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    cnt_a = 0; cnt_b = 0;
    for (int m = 0; m < 50; m++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (ifa.done) cnt_a++;
      if (ifb.done) cnt_b++;
    end
    chk("r035_done_count_a", 8'(cnt_a), 8'd3);
    chk("r035_done_count_b", 8'(cnt_b), 8'd4);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("r021_inv_priority_a", 8'(ifa.weights_valid), 8'h00);
    chk("r021_em_starts_a", 8'(ifa.enable_mult), 8'h02);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("r021_reuse_reloads_a", 8'(ifa.load_weight), 8'h01);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    for (int m = 0; m < 1000; m++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_scheduler.md
SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of PE rows (>=1).
REQ-002 SHALL have parameter COLS, default 4, number of PE columns (>=1).
REQ-003 SHALL have parameter PE_LATENCY, default 4, cycles per wavefront step (>=1).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  global advance enable; 0 freezes all state.
REQ-007 SHALL have port start  input  1  request one matrix operation; sampled only in IDLE.
REQ-008 SHALL have port reuse_weights  input  1  sampled with start; skip LOAD if weights are already valid.
REQ-009 SHALL have port invalidate  input  1  clear the weights_valid flag.
REQ-010 SHALL have port load_weight  output  ROWS  one-hot row weight-load strobe.
REQ-011 SHALL have port enable_mult  output  ROWS  per-row multiply enable.
REQ-012 SHALL have port busy  output  1  high in LOAD and COMPUTE.
REQ-013 SHALL have port done  output  1  single-cycle completion pulse.
REQ-014 SHALL have port weights_valid  output  1  loaded weights are usable.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, COMPUTE, DONE; all outputs registered.
REQ-016 SHALL, when en=0, hold state, counters and all outputs unchanged; start is ignored that cycle.
REQ-017 SHALL, in IDLE with en=1 and start=1, go to COMPUTE if reuse_weights=1 and weights_valid=1, else to LOAD.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in LOAD, spend exactly ROWS enabled cycles with load_weight equal to one-hot bit k on the k-th cycle (k=0..ROWS-1), then enter COMPUTE.
REQ-020 SHALL set weights_valid=1 on the LOAD-to-COMPUTE transition.
REQ-021 SHALL clear weights_valid on an enabled cycle with invalidate=1; invalidate takes priority over a simultaneous LOAD completion.
REQ-022 SHALL spend C=(ROWS+COLS-1)*PE_LATENCY enabled cycles in COMPUTE.
REQ-023 SHALL, on the first COMPUTE cycle, drive enable_mult with only the MSB set.
REQ-024 SHALL, every PE_LATENCY COMPUTE cycles, shift a 1 in at the MSB (next = {1, prev>>1}), saturating at all ones.
REQ-025 SHALL keep load_weight=0 outside LOAD and enable_mult=0 outside COMPUTE.
REQ-026 SHALL size counters to clog2(C+1) bits with no wrap inside an operation.
REQ-027 SHALL spend one enabled cycle in DONE with done=1 and busy=0, then return to IDLE.
REQ-028 SHALL accept a start on the first IDLE cycle after DONE, with no extra gap.

Reset
REQ-029 SHALL, on reset asserted (including mid-operation), enter IDLE immediately with load_weight=0, enable_mult=0, busy=0, done=0, weights_valid=0 and all counters 0.
REQ-030 SHALL leave reset synchronously on the first clk edge after deassertion, with no output glitch.

Verification
REQ-031 SHALL pass this case: ROWS=2, COLS=2, PE_LATENCY=4, en=1, start at edge 0 -> load_weight=01 in cycle 1 and 10 in cycle 2; enable_mult=10 in cycles 3-6 and 11 in cycles 7-14; done=1 in cycle 15; busy=1 in cycles 1-14.
REQ-032 SHALL pass this case: repeat the REQ-031 run with reuse_weights=1 after completion -> no load_weight pulses; enable_mult=10 from cycle 1; done 13 cycles after start.
REQ-033 SHALL pass this case: en=0 for 3 cycles at cycle 5 of the REQ-031 run -> outputs frozen for those cycles; done delayed to cycle 18.
REQ-034 SHALL pass this case: reset pulse at cycle 8 of the REQ-031 run -> all outputs 0 and weights_valid=0 at once; a later reuse_weights=1 start still performs LOAD.
REQ-035 SHALL pass this case: start held high continuously -> operations back-to-back with one IDLE cycle between done and the next LOAD; start is ignored while busy.
REQ-036 SHALL pass this case: ROWS=4, COLS=3, PE_LATENCY=1 -> enable_mult goes 1000, 1100, 1110, 1111 on successive cycles, COMPUTE lasts 6 cycles, and done arrives 11 cycles after start.
